lc3b_muldiv: RTL and testbench
==============================

Name: lc3b_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- Executes lc3b_aluop alu_mult (4'd10) and alu_div (4'd11) taken from the ID/EX control word.
- Drives a stall to the pipeline control while an operation runs, then presents a registered result for EX/MEM writeback.
- One operation in flight at a time; one bit is resolved per cycle.

Parameters:
WIDTH, 16, operand and result width (lc3b_word); iteration count equals WIDTH
DIV_ZERO_Q, 16'hFFFF, quotient returned on divide by zero

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE, acted on only when aluop is mult or div
aluop  input  4  lc3b_aluop from the EX control word
srca  input  WIDTH  multiplicand / dividend (SR1 value)
srcb  input  WIDTH  multiplier / divisor (SR2 or immediate value)
flush  input  1  abort from branch/trap redirect
stall  output  1  hold IF/ID/EX; combinational
done  output  1  single-cycle pulse: result valid
result  output  WIDTH  product low half, or quotient
remainder  output  WIDTH  remainder for div; 0 for mult
dz  output  1  divide-by-zero flag for the last div

Behaviour:
- States: IDLE, RUN, DONE; 5-bit iteration counter cnt.
- Reset (rst_n=0 at a clock edge): state=IDLE, cnt=0, result=0, remainder=0, dz=0, done=0. Reset dominates every other input, including mid-RUN; the operation in flight is lost with no done.
- IDLE:
  - Computes go = start & (aluop==alu_mult | aluop==alu_div) & ~flush.
  - stall = go, combinational, in the request cycle.
  - On go, latches operands and op at the edge, sets cnt=0, moves to RUN.
  - start with any other aluop is ignored: stall=0, no state change.
- RUN:
  - stall=1 and cnt increments each edge.
  - Moves to DONE on the edge where cnt==WIDTH-1.
  - This gives exactly WIDTH=16 RUN cycles.
- DONE:
  - done=1 and stall=0 for one cycle; the pipeline advances and captures result.
  - Next state is IDLE. The start input is not sampled in DONE.
- Latency: request accepted in cycle 0, RUN in cycles 1..16, done in cycle 17.
- result, remainder and dz are registered. They update at the edge entering DONE and hold until the next edge entering DONE or reset.
- Multiply:
  - Shift-add over 16 iterations.
  - result = (srca*srcb)[15:0], two's-complement low half, identical for signed and unsigned operands.
  - remainder=0, dz=0.
- Divide, signed, truncating toward zero:
  - Magnitudes feed an unsigned restoring divider, one quotient bit per RUN cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x8000 / 0xFFFF yields result 0x8000, remainder 0 (wraps; no flag).
- Divide by zero (srcb==0 at acceptance):
  - result=DIV_ZERO_Q, remainder=srca, dz=1.
  - Same 17-cycle latency; no early exit.
- flush:
  - In RUN: next state IDLE, no DONE/done, result/remainder/dz unchanged. stall drops at that same edge.
  - flush with start in IDLE: flush wins, the request is not accepted.
  - flush in DONE: done still pulses; the consumer discards it.
- Operands are sampled only at acceptance; srca, srcb and aluop changes during RUN have no effect.
- stall is never asserted in DONE, so a back-to-back mult/div issues its start in the cycle after DONE (earliest re-accept).

Test Plan:
- Reset then mult 0x0007*0x0006: stall=1 cycles 0..16, done=1 only in cycle 17, result=0x002A, remainder=0, dz=0.
- Mult 0x1234*0x0100 -> result 0x3400; mult 0xFFFF*0xFFFF -> 0x0001.
- Signed div:
  - 0xFFF9/0x0002 (-7/2) -> result 0xFFFD, remainder 0xFFFF.
  - 0x0064/0xFFF9 (100/-7) -> result 0xFFF2, remainder 0x0002.
  - 0x8000/0xFFFF -> result 0x8000, remainder 0.
- Div 0x0064/0x0000 -> done in cycle 17, result 0xFFFF, remainder 0x0064, dz=1; a following mult clears dz to 0.
- Control-path cases:
  - start with aluop=alu_add -> stall stays 0, no done.
  - flush at RUN cycle 5 -> IDLE next edge, stall=0, no done, previous result held; a new start in the next cycle completes normally.
  - rst_n=0 at RUN cycle 8 -> all outputs 0, IDLE, no done.

Source files
------------

// File: rtl/lc3b_muldiv.sv
// lc3b_muldiv -- iterative multiply/divide unit for the EX stage.
//
// This unit runs beside the single-cycle ALU and handles alu_mult and
// alu_div. An accepted request stalls the pipeline for WIDTH iterations,
// resolving one bit per cycle. A one-cycle done pulse then presents
// registered results for EX/MEM writeback.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request, sampled only in IDLE
//   aluop      lc3b_aluop from the EX control word (mult=10, div=11)
//   srca       multiplicand / dividend
//   srcb       multiplier / divisor
//   flush      abort from a branch/trap redirect
//   stall      combinational hold for IF/ID/EX
//   done       single-cycle result-valid pulse
//   result     low half of the product, or the quotient
//   remainder  remainder for div, 0 for mult
//   dz         divide-by-zero flag of the last completed op

module lc3b_muldiv #(
  parameter int unsigned        WIDTH      = 16,
  parameter logic [WIDTH-1:0]   DIV_ZERO_Q = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam logic [3:0] ALU_MULT = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state, w_stateNext;

  logic [4:0]       r_cnt;
  logic             r_isDiv;
  logic             r_dz;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dzOut;

  logic             w_isOp;
  logic             w_go;
  logic             w_last;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0] w_qNext;

  assign w_isOp = (aluop == ALU_MULT) || (aluop == ALU_DIV);
  assign w_go   = start && w_isOp && !flush;
  assign w_last = (r_cnt == CNT_LAST);

  // The divider works on magnitudes. 0x8000 maps to itself, which is the
  // correct unsigned magnitude.
  assign w_absA = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
  assign w_absB = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;

  // One iteration of either algorithm. The partial remainder is always
  // below the divisor (at most 0x8000), so the shifted value fits in WIDTH
  // bits. The top bit of w_diff is the borrow that decides the quotient bit.
  always_comb begin
    w_shift   = {r_acc, r_q[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_b};
    w_fits    = !w_diff[WIDTH];
    w_accNext = r_acc;
    w_qNext   = r_q;
    if (r_isDiv) begin
      w_accNext = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_qNext   = {r_q[WIDTH-2:0], w_fits};
    end else begin
      w_accNext = r_acc + (r_b[0] ? r_a : '0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state and control outputs. A flush in RUN has priority over
  // reaching the last iteration, so an aborted op never produces done.
  always_comb begin
    w_stateNext = r_state;
    stall       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_go;
        if (w_go) w_stateNext = RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (flush)       w_stateNext = IDLE;
        else if (w_last) w_stateNext = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath. In multiply mode r_a and r_b shift. In divide mode r_a keeps
  // the raw dividend, which is needed as the divide-by-zero remainder, and
  // r_b holds the divisor magnitude. Results load only on the edge that
  // enters DONE, so they include the final iteration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_isDiv     <= 1'b0;
      r_dz        <= 1'b0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_dzOut     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_cnt   <= '0;
            r_isDiv <= (aluop == ALU_DIV);
            r_dz    <= (aluop == ALU_DIV) && (srcb == '0);
            r_negQ  <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            r_negR  <= srca[WIDTH-1];
            r_a     <= srca;
            r_b     <= (aluop == ALU_DIV) ? w_absB : srcb;
            r_acc   <= '0;
            r_q     <= w_absA;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          r_acc <= w_accNext;
          r_q   <= w_qNext;
          if (!r_isDiv) begin
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end
          if (w_last && !flush) begin
            if (r_isDiv && r_dz) begin
              r_result    <= DIV_ZERO_Q;
              r_remainder <= r_a;
              r_dzOut     <= 1'b1;
            end else if (r_isDiv) begin
              r_result    <= r_negQ ? (~w_qNext + 1'b1) : w_qNext;
              r_remainder <= r_negR ? (~w_accNext + 1'b1) : w_accNext;
              r_dzOut     <= 1'b0;
            end else begin
              r_result    <= w_accNext;
              r_remainder <= '0;
              r_dzOut     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign remainder = r_remainder;
  assign dz        = r_dzOut;

endmodule

// File: tb/tb_lc3b_muldiv.sv
// tb_lc3b_muldiv -- directed testbench for lc3b_muldiv.
//
// Inputs change on the falling edge. Outputs are sampled 1ns later, well
// away from the rising edge.
// Expected values are hand-computed constants.

module tb_lc3b_muldiv;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_MULT = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  aluop;
  logic [15:0] srca;
  logic [15:0] srcb;
  logic        flush;
  logic        stall;
  logic        done;
  logic [15:0] result;
  logic [15:0] remainder;
  logic        dz;

  int compared   = 0;
  int mismatched = 0;

  lc3b_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .aluop     (aluop),
    .srca      (srca),
    .srcb      (srcb),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .remainder (remainder),
    .dz        (dz)
  );

  // 10ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. It counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op in the current cycle and checks every cycle through done.
  // It expects to be entered just after a falling edge and leaves just
  // after the falling edge that follows DONE.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expRes, input logic [15:0] expRem,
                               input logic expDz);
    start = 1'b1; aluop = op; srca = a; srcb = b;
    #1;
    checkOutput({tag, " stall c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      // Changing operands during RUN must have no effect on the result.
      srca = 16'h5A5A ^ 16'(c); srcb = 16'h00C3; aluop = ALU_ADD;
      #1;
      if (stall !== 1'b1 || done !== 1'b0)
        checkOutput($sformatf("%s run c%0d stall/done", tag, c), {30'd0, stall, done}, 32'b10);
    end
    @(negedge clk); #1;
    checkOutput({tag, " done c17"},  32'(done),      32'd1);
    checkOutput({tag, " stall c17"}, 32'(stall),     32'd0);
    checkOutput({tag, " result"},    32'(result),    32'(expRes));
    checkOutput({tag, " remainder"}, 32'(remainder), 32'(expRem));
    checkOutput({tag, " dz"},        32'(dz),        32'(expDz));
    @(negedge clk); #1;
    checkOutput({tag, " done drop"}, 32'(done),      32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; aluop = ALU_ADD; srca = '0; srcb = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset result", 32'(result),    32'd0);
    checkOutput("reset rem",    32'(remainder), 32'd0);
    checkOutput("reset dz",     32'(dz),        32'd0);
    checkOutput("reset done",   32'(done),      32'd0);
    checkOutput("reset stall",  32'(stall),     32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // The multiplies are issued back-to-back, each in the cycle after DONE.
    applyStimulus("mul7x6",     ALU_MULT, 16'h0007, 16'h0006, 16'h002A, 16'h0000, 1'b0);
    applyStimulus("mul1234",    ALU_MULT, 16'h1234, 16'h0100, 16'h3400, 16'h0000, 1'b0);
    applyStimulus("mulFFFF",    ALU_MULT, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    applyStimulus("div-7/2",    ALU_DIV,  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    applyStimulus("div100/-7",  ALU_DIV,  16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
    applyStimulus("div8000",    ALU_DIV,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    applyStimulus("div0",       ALU_DIV,  16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1);
    applyStimulus("mul3x5",     ALU_MULT, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0);

    // A start with a non-mult/div aluop is ignored.
    start = 1'b1; aluop = ALU_ADD; srca = 16'h0011; srcb = 16'h0022;
    #1;
    checkOutput("add stall", 32'(stall), 32'd0);
    repeat (3) begin
      @(negedge clk); #1;
      if (done !== 1'b0 || stall !== 1'b0)
        checkOutput("add idle", {30'd0, stall, done}, 32'd0);
    end
    checkOutput("add no done", 32'(done), 32'd0);
    start = 1'b0;

    // When flush and start arrive together, flush wins.
    @(negedge clk);
    start = 1'b1; aluop = ALU_MULT; flush = 1'b1;
    #1;
    checkOutput("flush+start stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush+start idle", 32'(stall), 32'd0);

    // A flush in RUN cycle 5 drops the op, with no done.
    start = 1'b1; aluop = ALU_MULT; srca = 16'h0002; srcb = 16'h0002;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    checkOutput("flush c5 stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush stall drop", 32'(stall),  32'd0);
    checkOutput("flush no done",    32'(done),   32'd0);
    checkOutput("flush held",       32'(result), 32'h000F);
    applyStimulus("post-flush", ALU_DIV, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0);

    // A reset in RUN cycle 8 clears everything, with no done.
    start = 1'b1; aluop = ALU_MULT; srca = 16'h0009; srcb = 16'h0009;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst result", 32'(result),    32'd0);
    checkOutput("midrst rem",    32'(remainder), 32'd0);
    checkOutput("midrst dz",     32'(dz),        32'd0);
    checkOutput("midrst stall",  32'(stall),     32'd0);
    checkOutput("midrst done",   32'(done),      32'd0);
    rst_n = 1'b1;
    begin
      logic sawDone;
      sawDone = 1'b0;
      repeat (20) begin
        @(negedge clk); #1;
        if (done === 1'b1) sawDone = 1'b1;
      end
      checkOutput("midrst never done", 32'(sawDone), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
